// File: rtl/picorv32_trace_pkg.sv
// Shared types and constants for the PicoRV32 trace capture path.
package picorv32_trace_pkg;

  localparam int unsigned TRACE_W = 36;

  localparam logic [3:0] TRACE_BRANCH = 4'b0001;
  localparam logic [3:0] TRACE_ADDR   = 4'b0010;
  localparam logic [3:0] TRACE_IRQ    = 4'b1000;

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] payload;
  } trace_word_t;

endpackage

// File: rtl/picorv32_trace_buffer_ram.sv
// Trace word storage: one synchronous write port, one asynchronous read port.
module trace_fifo_ram
  import picorv32_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  trace_word_t              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output trace_word_t              o_rdata_c
);

  trace_word_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/picorv32_trace_buffer.sv
// Circular capture buffer for the PicoRV32 trace port with overflow tracking.
module picorv32_trace_buffer
  import picorv32_trace_pkg::*;
#(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned STOP_ON_FULL = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_valid,
  input  logic [TRACE_W-1:0]       trace_data,
  input  logic                     enable,
  input  logic                     clear,
  output logic                     out_valid,
  output logic [TRACE_W-1:0]       out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned PW        = AW + 1;
  localparam logic        OVERWRITE = (STOP_ON_FULL == 0);

  logic [PW-1:0]    r_wptr, r_rptr, r_level;
  logic             r_out_valid, r_overflow;
  logic [CNT_W-1:0] r_drop_count;

  logic             w_push, w_pop, w_full, w_lose, w_we;
  logic [PW-1:0]    w_wptr_nxt, w_rptr_nxt;
  trace_word_t      w_rdata;

  assign w_push = trace_valid & enable & ~clear;
  assign w_pop  = r_out_valid & out_ready & ~clear;
  assign w_full = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) & (r_wptr[AW] != r_rptr[AW]);

  // A word is lost only when full with no pop to make room.
  assign w_lose = w_push & w_full & ~w_pop;
  assign w_we   = w_push & (~w_full | w_pop | OVERWRITE);

  assign w_wptr_nxt = r_wptr + PW'(w_we);
  assign w_rptr_nxt = r_rptr + PW'(w_pop | (w_lose & OVERWRITE));

  trace_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (r_wptr[AW-1:0]),
    .i_wdata   (trace_data),
    .i_raddr   (r_rptr[AW-1:0]),
    .o_rdata_c (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_level     <= w_wptr_nxt - w_rptr_nxt;
      r_out_valid <= (w_wptr_nxt != w_rptr_nxt);
      if (w_lose) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = w_rdata;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_picorv32_trace_buffer.sv
// Randomized bench: three buffer configurations checked against a queue model.
module tb_picorv32_trace_buffer;

  logic        clk;
  logic        rst, tv, en, clr, rdy;
  logic [35:0] td;

  logic        ov_a, ov_b, ov_c, of_a, of_b, of_c;
  logic [35:0] od_a, od_b, od_c;
  logic [2:0]  lv_a, lv_b;
  logic [6:0]  lv_c;
  logic [15:0] dc_a, dc_c;
  logic [3:0]  dc_b;

  int n_cmp = 0;
  int n_err = 0;

  int          mdepth [3] = '{4, 4, 64};
  bit          msof   [3] = '{1'b0, 1'b1, 1'b0};
  int          mcmax  [3] = '{65535, 15, 65535};
  logic [35:0] mq     [3][$];
  int          mdrop  [3];
  bit          movf   [3];

  picorv32_trace_buffer #(.DEPTH(4), .STOP_ON_FULL(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .trace_valid(tv), .trace_data(td), .enable(en), .clear(clr),
    .out_valid(ov_a), .out_data(od_a), .out_ready(rdy), .level(lv_a), .overflow(of_a),
    .drop_count(dc_a));

  picorv32_trace_buffer #(.DEPTH(4), .STOP_ON_FULL(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .trace_valid(tv), .trace_data(td), .enable(en), .clear(clr),
    .out_valid(ov_b), .out_data(od_b), .out_ready(rdy), .level(lv_b), .overflow(of_b),
    .drop_count(dc_b));

  picorv32_trace_buffer dut_c (
    .clk(clk), .rst(rst), .trace_valid(tv), .trace_data(td), .enable(en), .clear(clr),
    .out_valid(ov_c), .out_data(od_c), .out_ready(rdy), .level(lv_c), .overflow(of_c),
    .drop_count(dc_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: a bounded queue with overwrite-oldest or drop-newest on overflow.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst || clr) begin
        mq[i].delete();
        mdrop[i] = 0;
        movf[i]  = 1'b0;
      end else begin
        int  sz;
        bit  push, pop;
        sz   = mq[i].size();
        pop  = (sz > 0) && rdy;
        push = tv && en;
        if (push && sz == mdepth[i] && !pop) begin
          movf[i] = 1'b1;
          if (mdrop[i] < mcmax[i]) mdrop[i]++;
          if (!msof[i]) begin
            void'(mq[i].pop_front());
            mq[i].push_back(td);
          end
        end else begin
          if (pop)  void'(mq[i].pop_front());
          if (push) mq[i].push_back(td);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic        v   [3];
    logic [35:0] d   [3];
    logic [63:0] l   [3];
    logic [63:0] c   [3];
    logic        o   [3];
    v = '{ov_a, ov_b, ov_c};
    d = '{od_a, od_b, od_c};
    l = '{64'(lv_a), 64'(lv_b), 64'(lv_c)};
    c = '{64'(dc_a), 64'(dc_b), 64'(dc_c)};
    o = '{of_a, of_b, of_c};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("out_valid[%0d]", i), 64'(v[i]), 64'(mq[i].size() > 0));
      check($sformatf("level[%0d]", i), l[i], 64'(mq[i].size()));
      check($sformatf("overflow[%0d]", i), 64'(o[i]), 64'(movf[i]));
      check($sformatf("drop_count[%0d]", i), c[i], 64'(mdrop[i]));
      if (mq[i].size() > 0) check($sformatf("out_data[%0d]", i), 64'(d[i]), 64'(mq[i][0]));
    end
  endtask

  task automatic cyc(input bit v, input logic [35:0] d, input bit e, input bit r,
                     input bit c, input bit rs);
    tv = v; td = d; en = e; rdy = r; clr = c; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    tv = 0; td = '0; en = 1; rdy = 0; clr = 0; rst = 1;

    // reset
    cyc(0, '0, 1, 0, 0, 1);
    cyc(0, '0, 1, 0, 0, 1);
    check("reset_level_a", 64'(lv_a), 64'd0);
    check("reset_valid_c", 64'(ov_c), 64'd0);

    // basic: three words then drain in order
    cyc(1, 36'h1_00000010, 1, 0, 0, 0);
    check("basic_valid_after_first", 64'(ov_c), 64'd1);
    cyc(1, 36'h2_00000020, 1, 0, 0, 0);
    cyc(1, 36'h8_00000030, 1, 0, 0, 0);
    check("basic_level", 64'(lv_c), 64'd3);
    check("basic_head", 64'(od_c), 64'h1_00000010);
    for (int k = 0; k < 4; k++) cyc(0, '0, 1, 1, 0, 0);
    check("basic_empty", 64'(ov_c), 64'd0);
    cyc(0, '0, 1, 0, 1, 0);

    // words 1..6 into depth 4: overwrite keeps 3..6, stop keeps 1..4
    for (int k = 1; k <= 6; k++) cyc(1, 36'(k), 1, 0, 0, 0);
    check("ow_head", 64'(od_a), 64'd3);
    check("ow_drops", 64'(dc_a), 64'd2);
    check("stop_head", 64'(od_b), 64'd1);
    check("stop_drops", 64'(dc_b), 64'd2);
    for (int k = 0; k < 5; k++) cyc(0, '0, 1, 1, 0, 0);
    cyc(0, '0, 1, 0, 1, 0);

    // full with simultaneous push and pop
    for (int k = 0; k < 4; k++) cyc(1, 36'h100 + 36'(k), 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1, 36'h200 + 36'(k), 1, 1, 0, 0);
      check("full_pp_level_b", 64'(lv_b), 64'd4);
    end
    check("full_pp_no_drop_b", 64'(dc_b), 64'd0);

    // enable low: no capture, drain still works
    for (int k = 0; k < 3; k++) cyc(1, 36'h300, 0, 0, 0, 0);
    check("enable_low_level_a", 64'(lv_a), 64'd4);
    cyc(1, 36'h301, 0, 1, 0, 0);

    // clear with a concurrent push
    cyc(1, 36'h400, 1, 1, 1, 0);
    check("clear_level_c", 64'(lv_c), 64'd0);
    check("clear_valid_b", 64'(ov_b), 64'd0);

    // saturation of the 4-bit drop counter
    for (int k = 0; k < 24; k++) cyc(1, 36'h500 + 36'(k), 1, 0, 0, 0);
    check("sat_drop_b", 64'(dc_b), 64'd15);
    cyc(0, '0, 1, 0, 1, 0);

    // random traffic, first fill-biased then drain-biased
    for (int k = 0; k < 4000; k++) begin
      bit v, e, r, c, rs;
      v  = ($urandom % 4) != 0;
      e  = ($urandom % 8) != 0;
      r  = (k < 2000) ? (($urandom % 3) == 0) : (($urandom % 4) != 0);
      c  = ($urandom % 97) == 0;
      rs = ($urandom % 251) == 0;
      cyc(v, {4'($urandom), 32'($urandom)}, e, r, c, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
